// File: rtl/npc_resolver.sv
// npc_resolver: resolves the architectural next PC in execute, compares it with
// the fetch prediction, and on a mismatch pulses flush and holds a redirect
// request to fetch (valid/ready) while stalling execute.
// Optional statistics counters are built when NPC_RESOLVER_STATS_EN is defined;
// otherwise branch_count and mispredict_count are tied to zero.
module npc_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  npc_op1,
  input  logic [XLEN-1:0]  npc_op2,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_jalr,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  pred_npc,
  output logic             resolved_valid,
  output logic [XLEN-1:0]  resolved_npc,
  output logic             misalign_exc,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t            state_reg, state_next;
  logic              resolved_valid_reg, resolved_valid_next;
  logic [XLEN-1:0]   resolved_npc_reg, resolved_npc_next;
  logic              misalign_reg, misalign_next;
  logic              flush_reg, flush_next;
  logic              redirect_valid_reg, redirect_valid_next;
  logic [XLEN-1:0]   redirect_pc_reg, redirect_pc_next;

  logic              accept;
  logic [XLEN-1:0]   sum;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   actual;
  logic              taken;
  logic              misaligned;
  logic              mispredict;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  // Next-PC datapath; everything here is purely combinational from execute inputs.
  assign ex_ready   = (state_reg == IDLE);
  assign accept     = ex_valid && ex_ready;
  assign sum        = npc_op1 + npc_op2;
  assign target     = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign seq_pc     = ex_pc + PC_STEP;
  assign taken      = is_jump | is_jalr | (is_branch & br_taken);
  assign actual     = taken ? target : seq_pc;
  assign misaligned = taken && (target[1:0] != 2'b00);
  // A misaligned target raises an exception instead of redirecting fetch.
  assign mispredict = !misaligned && (actual != pred_npc);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      resolved_valid_reg <= 1'b0;
      resolved_npc_reg   <= '0;
      misalign_reg       <= 1'b0;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      state_reg          <= state_next;
      resolved_valid_reg <= resolved_valid_next;
      resolved_npc_reg   <= resolved_npc_next;
      misalign_reg       <= misalign_next;
      flush_reg          <= flush_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
    end
  end

  // Next-state and next-output decode; pulses default low, redirect request holds.
  always_comb begin
    state_next          = state_reg;
    resolved_valid_next = 1'b0;
    resolved_npc_next   = resolved_npc_reg;
    misalign_next       = 1'b0;
    flush_next          = 1'b0;
    redirect_valid_next = redirect_valid_reg;
    redirect_pc_next    = redirect_pc_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          resolved_valid_next = 1'b1;
          resolved_npc_next   = actual;
          if (misaligned) begin
            misalign_next = 1'b1;
            flush_next    = 1'b1;
          end else if (mispredict) begin
            flush_next          = 1'b1;
            redirect_valid_next = 1'b1;
            redirect_pc_next    = actual;
            state_next          = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        // Execute is on the wrong path here, so ex_valid is not looked at.
        if (redirect_ready) begin
          redirect_valid_next = 1'b0;
          state_next          = IDLE;
        end
      end
      default: begin
        state_next          = IDLE;
        redirect_valid_next = 1'b0;
      end
    endcase
  end

  assign resolved_valid = resolved_valid_reg;
  assign resolved_npc   = resolved_npc_reg;
  assign misalign_exc   = misalign_reg;
  assign flush          = flush_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

`ifdef NPC_RESOLVER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] branch_count_reg;
  logic [CNT_W-1:0] mispredict_count_reg;
  logic             count_branch;
  logic             count_mispredict;

  assign count_branch     = accept && (is_branch | is_jump | is_jalr);
  assign count_mispredict = accept && mispredict;

  // Saturating counters, updated on the accept edge so they move with resolved_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (count_branch && (branch_count_reg != '1))
        branch_count_reg <= branch_count_reg + CNT_ONE;
      if (count_mispredict && (mispredict_count_reg != '1))
        mispredict_count_reg <= mispredict_count_reg + CNT_ONE;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_npc_resolver.sv
// Bench for npc_resolver: expected results from a reference model are queued
// when an instruction is accepted and compared against DUT output records.
module tb_npc_resolver;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_ready;
  logic [XLEN-1:0]  ex_pc = '0;
  logic [XLEN-1:0]  npc_op1 = '0;
  logic [XLEN-1:0]  npc_op2 = '0;
  logic             is_branch = 1'b0;
  logic             is_jump = 1'b0;
  logic             is_jalr = 1'b0;
  logic             br_taken = 1'b0;
  logic [XLEN-1:0]  pred_npc = '0;
  logic             resolved_valid;
  logic [XLEN-1:0]  resolved_npc;
  logic             misalign_exc;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ready = 1'b0;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  typedef struct packed {
    logic [31:0] npc;
    logic        flsh;
    logic        mis;
    logic        redir;
    logic [31:0] rpc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   br_model = 0;
  int   mis_model = 0;

  npc_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .npc_op1(npc_op1), .npc_op2(npc_op2),
    .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
    .br_taken(br_taken), .pred_npc(pred_npc),
    .resolved_valid(resolved_valid), .resolved_npc(resolved_npc),
    .misalign_exc(misalign_exc), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Expected counter values as seen by the bench (zero when stats are compiled out).
  function automatic int exp_br();
`ifdef NPC_RESOLVER_STATS_EN
    return br_model;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_mis();
`ifdef NPC_RESOLVER_STATS_EN
    return mis_model;
`else
    return 0;
`endif
  endfunction

  // Advance one clock and record any result the DUT presents after the edge.
  task automatic tick();
    rec_t r;
    @(posedge clk);
    #1;
    if (resolved_valid || flush || misalign_exc) begin
      r.npc   = resolved_npc;
      r.flsh  = flush;
      r.mis   = misalign_exc;
      r.redir = redirect_valid;
      r.rpc   = redirect_pc;
      obs_q.push_back(r);
    end
  endtask

  // Present one instruction; if it will be accepted, queue the model's prediction.
  task automatic drive_instr(input logic [31:0] pc, input logic [31:0] op1,
                             input logic [31:0] op2, input logic br, input logic jmp,
                             input logic jalr, input logic tk, input logic [31:0] pred);
    logic [31:0] tgt;
    logic [31:0] act;
    logic        t;
    rec_t        e;
    ex_valid = 1'b1; ex_pc = pc; npc_op1 = op1; npc_op2 = op2;
    is_branch = br; is_jump = jmp; is_jalr = jalr; br_taken = tk; pred_npc = pred;
    if (ex_ready) begin
      tgt = op1 + op2;
      if (jalr) tgt[0] = 1'b0;
      t   = jmp | jalr | (br & tk);
      act = t ? tgt : pc + 32'd4;
      e.npc   = act;
      e.mis   = t && (tgt[1:0] != 2'b00);
      e.redir = !e.mis && (act != pred);
      e.flsh  = e.mis || e.redir;
      e.rpc   = act;
      exp_q.push_back(e);
      if ((br | jmp | jalr) && br_model < 15) br_model++;
      if (e.redir && mis_model < 15) mis_model++;
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; is_branch = 1'b0; is_jump = 1'b0; is_jalr = 1'b0; br_taken = 1'b0;
  endtask

  // Pop every observed record and compare it with the oldest expectation.
  task automatic scoreboard_drain(input string tag);
    rec_t o;
    rec_t e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s unexpected output npc=%h flush=%b mis=%b redir=%b", tag, o.npc, o.flsh, o.mis, o.redir);
      end else begin
        e = exp_q.pop_front();
        if (o.npc !== e.npc || o.flsh !== e.flsh || o.mis !== e.mis || o.redir !== e.redir ||
            (e.redir && o.rpc !== e.rpc))
          $display("FAIL %s got npc=%h flush=%b mis=%b redir=%b rpc=%h expected npc=%h flush=%b mis=%b redir=%b rpc=%h",
                   tag, o.npc, o.flsh, o.mis, o.redir, o.rpc, e.npc, e.flsh, e.mis, e.redir, e.rpc);
        else begin
          pass_cnt++;
          $display("txn %s npc=%h flush=%b mis=%b redir=%b", tag, o.npc, o.flsh, o.mis, o.redir);
        end
      end
    end
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL %s missing outputs got 0 pending required 0 pending=%0d", tag, exp_q.size());
    else
      pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (ex_ready !== 1'b1 || resolved_valid !== 1'b0 || flush !== 1'b0 || misalign_exc !== 1'b0 ||
        redirect_valid !== 1'b0 || resolved_npc !== 32'h0 || redirect_pc !== 32'h0 ||
        branch_count !== 4'h0 || mispredict_count !== 4'h0)
      $display("FAIL reset_state got rdy=%b rv=%b fl=%b mx=%b rdv=%b npc=%h rpc=%h bc=%0d mc=%0d required rdy=1 rest 0",
               ex_ready, resolved_valid, flush, misalign_exc, redirect_valid, resolved_npc, redirect_pc,
               branch_count, mispredict_count);
    else pass_cnt++;
    rst_n = 1'b1;
    br_model = 0; mis_model = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_sequential();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive_instr(32'h100 + 32'(i) * 4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104 + 32'(i) * 4);
      tick();
      if (resolved_valid) pulses++;
      total_cnt++;
      if (ex_ready !== 1'b1 || resolved_valid !== 1'b1)
        $display("FAIL seq_no_bubble[%0d] got rdy=%b rv=%b required 1/1", i, ex_ready, resolved_valid);
      else pass_cnt++;
    end
    idle_inputs();
    tick();
    total_cnt++;
    if (pulses != 10 || resolved_valid !== 1'b0)
      $display("FAIL seq_pulse_count got %0d tail_rv=%b required 10 tail 0", pulses, resolved_valid);
    else pass_cnt++;
    scoreboard_drain("sequential");
  endtask

  task automatic test_mispredict();
    drive_instr(32'h200, 32'h200, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h204);
    tick();
    total_cnt++;
    if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h240 || ex_ready !== 1'b0 ||
        branch_count !== 4'(exp_br()) || mispredict_count !== 4'(exp_mis()))
      $display("FAIL mispredict_entry got fl=%b rdv=%b rpc=%h rdy=%b bc=%0d mc=%0d required 1 1 00000240 0 %0d %0d",
               flush, redirect_valid, redirect_pc, ex_ready, branch_count, mispredict_count, exp_br(), exp_mis());
    else pass_cnt++;
    // wrong-path instruction keeps arriving while fetch stalls
    drive_instr(32'h204, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h240 || ex_ready !== 1'b0 ||
          resolved_valid !== 1'b0)
        $display("FAIL redirect_hold[%0d] got fl=%b rdv=%b rpc=%h rdy=%b rv=%b required 0 1 00000240 0 0",
                 i, flush, redirect_valid, redirect_pc, ex_ready, resolved_valid);
      else pass_cnt++;
    end
    redirect_ready = 1'b1;
    tick();
    idle_inputs();
    total_cnt++;
    if (redirect_valid !== 1'b0 || ex_ready !== 1'b1)
      $display("FAIL redirect_release got rdv=%b rdy=%b required 0 1", redirect_valid, ex_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (redirect_valid !== 1'b0 || ex_ready !== 1'b1 || resolved_valid !== 1'b0)
      $display("FAIL ready_while_idle got rdv=%b rdy=%b rv=%b required 0 1 0", redirect_valid, ex_ready, resolved_valid);
    else pass_cnt++;
    redirect_ready = 1'b0;
    scoreboard_drain("mispredict");
  endtask

  task automatic test_misalign();
    drive_instr(32'h800, 32'h1001, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000);
    tick();
    idle_inputs();
    total_cnt++;
    if (misalign_exc !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b0 || resolved_npc !== 32'h1002 ||
        ex_ready !== 1'b1)
      $display("FAIL misalign got mx=%b fl=%b rdv=%b npc=%h rdy=%b required 1 1 0 00001002 1",
               misalign_exc, flush, redirect_valid, resolved_npc, ex_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (misalign_exc !== 1'b0 || flush !== 1'b0)
      $display("FAIL misalign_one_cycle got mx=%b fl=%b required 0 0", misalign_exc, flush);
    else pass_cnt++;
    scoreboard_drain("misalign");
  endtask

  task automatic test_wrap_and_jump();
    drive_instr(32'hFFFF_FFFC, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive_instr(32'h3000, 32'h3000, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3010);
    tick();
    total_cnt++;
    if (flush !== 1'b0 || resolved_npc !== 32'h3010)
      $display("FAIL jump_correct got fl=%b npc=%h required 0 00003010", flush, resolved_npc);
    else pass_cnt++;
    drive_instr(32'h4000, 32'h5001, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000);
    tick();
    idle_inputs();
    tick();
    scoreboard_drain("wrap_jump");
  endtask

  task automatic test_reset_redirect();
    drive_instr(32'h600, 32'h600, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h604);
    tick();
    idle_inputs();
    scoreboard_drain("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || ex_ready !== 1'b1 || redirect_pc !== 32'h0)
      $display("FAIL reset_mid_redirect got rdv=%b fl=%b rdy=%b rpc=%h required 0 0 1 00000000",
               redirect_valid, flush, ex_ready, redirect_pc);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    br_model = 0; mis_model = 0;
    obs_q.delete(); exp_q.delete();
    tick();
    total_cnt++;
    if (ex_ready !== 1'b1 || redirect_valid !== 1'b0)
      $display("FAIL after_reset_release got rdy=%b rdv=%b required 1 0", ex_ready, redirect_valid);
    else pass_cnt++;
  endtask

  task automatic test_stats();
    redirect_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_instr(32'h1000 + 32'(i) * 16, 32'h2000, 32'(i) * 4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      idle_inputs();
      if (i == 4) begin
        total_cnt++;
        if (mispredict_count !== 4'(exp_mis()) || branch_count !== 4'(exp_br()))
          $display("FAIL stats_mid got mc=%0d bc=%0d required %0d %0d", mispredict_count, branch_count, exp_mis(), exp_br());
        else pass_cnt++;
      end
      tick();
    end
    redirect_ready = 1'b0;
    total_cnt++;
    if (mispredict_count !== 4'(exp_mis()) || branch_count !== 4'(exp_br()))
      $display("FAIL stats_saturate got mc=%0d bc=%0d required %0d %0d", mispredict_count, branch_count, exp_mis(), exp_br());
    else pass_cnt++;
    scoreboard_drain("stats");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mispredict();
    test_misalign();
    test_wrap_and_jump();
    test_reset_redirect();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
